// File: rtl/mseq_if.sv
// Sequencer-to-core bus: opcode and ROM word in, micro-address and control word out.
// master is the sequencer; slave is the surrounding core/ROM.
interface mseq_if #(
   parameter int CW    = 32,
   parameter int AW    = 10,
   parameter int DEPTH = 4
);
   logic [7:0]               DB;
   logic [CW-1:0]            udata;
   logic                     rdy;
   logic                     cond;
   logic                     irq;
   logic                     nmi;
   logic                     I;
   logic [AW-1:0]            uaddr;
   logic [CW-1:0]            ctrl;
   logic                     sync;
   logic                     stk_ovf;
   logic                     stk_unf;
   logic [$clog2(DEPTH):0]   stk_lvl;

   modport master (
      input  DB, udata, rdy, cond, irq, nmi, I,
      output uaddr, ctrl, sync, stk_ovf, stk_unf, stk_lvl
   );

   modport slave (
      output DB, udata, rdy, cond, irq, nmi, I,
      input  uaddr, ctrl, sync, stk_ovf, stk_unf, stk_lvl
   );
endinterface

// File: rtl/mseq.sv
// Microcode sequencer: registered control word, next-address selection,
// return stack with sticky over/underflow flags, and NMI/IRQ vectoring on opcode decode.
module mseq #(
   parameter int            CW        = 32,
   parameter int            AW        = 10,
   parameter int            FW        = 5,
   parameter int            DEPTH     = 4,
   parameter logic [AW-1:0] FBASE     = 10'h140,
   parameter logic [AW-1:0] RESET_VEC = 10'h160,
   parameter logic [AW-1:0] IRQ_VEC   = 10'h168,
   parameter logic [AW-1:0] NMI_VEC   = 10'h170
) (
   input  logic   clk,
   input  logic   reset,
   mseq_if.master bus
);

   localparam int PW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      S_DECODE    = 3'b000,
      S_NEXT      = 3'b001,
      S_FINISH    = 3'b010,
      S_NEXT_SAVE = 3'b011,
      S_CALL      = 3'b100,
      S_BRT       = 3'b101,
      S_BRF       = 3'b110,
      S_RET       = 3'b111
   } seq_t;

   logic [CW-1:0] ctrl;
   logic [AW-1:0] upc;
   logic [FW-1:0] finish;
   logic [AW-1:0] stack [DEPTH];
   logic [PW-1:0] tp;
   logic [PW:0]   lvl;
   logic          first;
   logic          nmi_q;
   logic          nmi_pend;
   logic          ovf;
   logic          unf;

   seq_t          seq;
   logic [AW-1:0] nxt;
   logic [FW-1:0] fin_fld;
   logic [AW-1:0] upc_inc;
   logic [AW-1:0] pop_val;
   logic [AW-1:0] uaddr;
   logic          empty;
   logic          full;
   logic          adv;
   logic          take_nmi;

   assign seq      = seq_t'(ctrl[CW-1:CW-3]);
   assign nxt      = ctrl[AW-1:0];
   assign fin_fld  = ctrl[AW+FW-1:AW];
   assign upc_inc  = upc + AW'(1);
   // tp points at the next free slot, so the top of stack sits one below it
   assign pop_val  = stack[tp - PW'(1)];
   assign empty    = (lvl == '0);
   assign full     = (lvl == (PW+1)'(DEPTH));
   assign adv      = bus.rdy & ~first;
   assign take_nmi = adv & (seq == S_DECODE) & nmi_pend;

   always_comb begin
      uaddr = upc_inc;
      if (first) begin
         uaddr = RESET_VEC;
      end else begin
         case (seq)
            S_DECODE: begin
               if (nmi_pend)
                  uaddr = NMI_VEC;
               else if (bus.irq & ~bus.I)
                  uaddr = IRQ_VEC;
               else
                  uaddr = AW'(bus.DB);
            end
            S_NEXT, S_NEXT_SAVE, S_CALL: uaddr = nxt;
            S_FINISH: uaddr = FBASE + AW'(finish);
            S_BRT:    uaddr = bus.cond ? nxt : upc_inc;
            S_BRF:    uaddr = bus.cond ? upc_inc : nxt;
            S_RET:    uaddr = empty ? RESET_VEC : pop_val;
            default:  uaddr = upc_inc;
         endcase
      end
   end

   // The reset fetch loads ctrl/upc but must not act on the cleared ctrl word,
   // hence stack, finish and NMI-clear effects are gated by adv rather than rdy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl     <= '0;
         upc      <= RESET_VEC;
         finish   <= '0;
         for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
         tp       <= '0;
         lvl      <= '0;
         ovf      <= 1'b0;
         unf      <= 1'b0;
         nmi_q    <= 1'b0;
         nmi_pend <= 1'b0;
         first    <= 1'b1;
      end else begin
         first    <= 1'b0;
         nmi_q    <= bus.nmi;
         nmi_pend <= (nmi_pend & ~take_nmi) | (bus.nmi & ~nmi_q);
         if (bus.rdy) begin
            ctrl <= bus.udata;
            upc  <= uaddr;
         end
         if (adv) begin
            case (seq)
               S_NEXT_SAVE: finish <= fin_fld;
               S_CALL: begin
                  stack[tp] <= upc_inc;
                  tp        <= tp + PW'(1);
                  if (full)
                     ovf <= 1'b1;
                  else
                     lvl <= lvl + (PW+1)'(1);
               end
               S_RET: begin
                  if (empty) begin
                     unf <= 1'b1;
                  end else begin
                     tp  <= tp - PW'(1);
                     lvl <= lvl - (PW+1)'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.uaddr   = uaddr;
   assign bus.ctrl    = ctrl;
   assign bus.sync    = (seq == S_DECODE) & bus.rdy & ~first;
   assign bus.stk_ovf = ovf;
   assign bus.stk_unf = unf;
   assign bus.stk_lvl = lvl;

endmodule

// File: doc/mseq.md
MSEQ -- requirements
Module: mseq

Interface
REQ-001 SHALL provide parameter CW, default 32: control word width, >= AW+FW+3.
REQ-002 SHALL provide parameter AW, default 10: micro-address width, >= 9.
REQ-003 SHALL provide parameter FW, default 5: finisher index width.
REQ-004 SHALL provide parameter DEPTH, default 4: return-stack entries, power of 2, >= 2.
REQ-005 SHALL provide parameters FBASE 10'h140, RESET_VEC 10'h160, IRQ_VEC 10'h168, NMI_VEC 10'h170, all AW bits wide.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low.
REQ-008 SHALL have port DB, input, 8 bits: opcode byte on the data bus.
REQ-009 SHALL have port udata, input, CW bits: microcode ROM word at uaddr, combinational.
REQ-010 SHALL have ports rdy, cond, irq, nmi, I, each input, 1 bit: stall-low, micro-branch condition, level IRQ, edge NMI, interrupt mask.
REQ-011 SHALL have port uaddr, output, AW bits: next micro-address, combinational.
REQ-012 SHALL have port ctrl, output, CW bits: current control register.
REQ-013 SHALL have port sync, output, 1 bit: opcode fetch cycle.
REQ-014 SHALL have ports stk_ovf and stk_unf, output, 1 bit each: sticky return-stack error flags.
REQ-015 SHALL have port stk_lvl, output, log2(DEPTH)+1 bits: return-stack occupancy.

Function
REQ-016 SHALL decode fields seq=ctrl[CW-1:CW-3], next=ctrl[AW-1:0], fin=ctrl[AW+FW-1:AW].
REQ-017 SHALL hold upc, the address ctrl was fetched from; on each advancing edge ctrl<=udata and upc<=uaddr.
REQ-018 SHALL compute uaddr per seq: 000 DECODE, 001 NEXT, 010 FINISH, 011 NEXT_SAVE, 100 CALL, 101 BRT, 110 BRF, 111 RET.
REQ-019 SHALL, on DECODE, select NMI_VEC if NMI pending, else IRQ_VEC if irq & ~I, else zero-extended DB.
REQ-020 SHALL, on NEXT, select next; on NEXT_SAVE, select next and capture fin into the finish register.
REQ-021 SHALL, on FINISH, select FBASE + finish, truncated to AW bits.
REQ-022 SHALL, on CALL, push upc+1 and select next; on RET, pop and select the popped value.
REQ-023 SHALL select next on BRT when cond=1 and on BRF when cond=0; otherwise select upc+1.
REQ-024 SHALL compute upc+1 modulo 2^AW, wrapping from all-ones to 0.
REQ-025 SHALL, on CALL with the stack full, overwrite the oldest entry, keep stk_lvl=DEPTH, and set stk_ovf.
REQ-026 SHALL, on RET with the stack empty, select RESET_VEC, keep stk_lvl=0, and set stk_unf.
REQ-027 SHALL set a pending latch on each nmi 0->1 edge, with nmi sampled one cycle late.
REQ-028 SHALL clear the pending latch on the advancing DECODE edge that selects NMI_VEC; an edge on that same cycle stays pending.
REQ-029 SHALL, while rdy=0, hold ctrl, upc, finish, stack and stk_lvl, and keep uaddr stable for stable inputs.
REQ-030 SHALL, while rdy=0, keep the NMI edge detector active and the error flags sticky.
REQ-031 SHALL assert sync = (seq==DECODE) & rdy & ~first; sync SHALL be 0 in all other cases.
REQ-032 SHALL clear stk_ovf and stk_unf only by reset.

Reset
REQ-033 SHALL, while reset=0, asynchronously clear ctrl, finish, stack, stk_lvl, flags, NMI latch and NMI sample, and set upc=RESET_VEC.
REQ-034 SHALL set a first flag during reset and force uaddr=RESET_VEC while it is set.
REQ-035 SHALL clear the first flag on the first rising edge after release, making the first fetched word ROM[RESET_VEC].
REQ-036 SHALL, when reset is asserted mid-instruction, abandon the stack contents and pending NMI, with no partial state surviving.

Verification
REQ-037 SHALL cover: release reset, ROM[160]=NEXT->0x200 -> uaddr 0x160, then 0x200; sync=0 throughout.
REQ-038 SHALL cover: DECODE with DB=0xA9, I=1, irq=1 -> uaddr 0x0A9; repeat with I=0 -> 0x168.
REQ-039 SHALL cover: nmi pulse during a NEXT chain, then DECODE with irq=1, I=0 -> 0x170 once; the next DECODE gives DB or 0x168.
REQ-040 SHALL cover: NEXT_SAVE fin=3, then FINISH -> uaddr 0x143; CALL at upc 0x205 to 0x300, then RET -> 0x206.
REQ-041 SHALL cover: 5 nested CALLs -> stk_lvl=4, stk_ovf=1; 5 RETs -> 4 valid returns, then 0x160 with stk_unf=1.
REQ-042 SHALL cover: BRT cond=0 at upc 0x3FF -> uaddr 0x000; rdy=0 for 3 cycles mid-CALL -> no push, ctrl and stk_lvl unchanged.
